mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sequences each access with a req/ready handshake to the memory.
- Gives data accesses priority, with a bounded-starvation guard for fetch.
- Drives per-stage stall requests into the pipeline hazard logic and keeps a 16-bit conflict counter.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// with data priority bounded by a starvation guard for fetch.
//
// state   | meaning
// IDLE    | no access outstanding, mem_req low
// IF_BUSY | fetch access presented to memory, waiting for mem_ready
// DM_BUSY | data access presented to memory, waiting for mem_ready
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int DM_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [DW-1:0] if_data,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_f,
    output logic          stall_m,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [15:0]   conflict_cnt
);

    localparam int SW = $clog2(DM_MAX + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} stateT;

    stateT          state;
    stateT          stateNext;
    logic [SW-1:0]  starvCnt;
    logic [SW-1:0]  starvNext;
    logic           ifElig;
    logic           dmElig;
    logic           arbEn;
    logic           starved;
    logic           grantDm;
    logic           grantIf;
    logic           conflictHit;

    assign stall_f = if_req & ~if_valid;
    assign stall_m = (dm_rd | dm_wr) & ~dm_valid;

    always_comb begin
        ifElig      = if_req & ~if_valid;
        dmElig      = (dm_rd | dm_wr) & ~dm_valid;
        arbEn       = (state == IDLE) | mem_ready;
        starved     = ifElig & (starvCnt == SW'(DM_MAX));
        grantDm     = arbEn & dmElig & ~starved;
        grantIf     = arbEn & ifElig & ~grantDm;
        conflictHit = ifElig & ((state == DM_BUSY) | grantDm);

        stateNext = state;
        if (arbEn) begin
            if (grantDm) begin
                stateNext = DM_BUSY;
            end else if (grantIf) begin
                stateNext = IF_BUSY;
            end else begin
                stateNext = IDLE;
            end
        end

        // Fetch going quiet or being served resets its patience.
        starvNext = starvCnt;
        if (!ifElig || grantIf) begin
            starvNext = '0;
        end else if (grantDm) begin
            starvNext = starvCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            starvCnt     <= '0;
            if_valid     <= 1'b0;
            if_data      <= '0;
            dm_valid     <= 1'b0;
            dm_rdata     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            state    <= stateNext;
            starvCnt <= starvNext;
            if_valid <= (state == IF_BUSY) & mem_ready;
            dm_valid <= (state == DM_BUSY) & mem_ready;

            if (state == IF_BUSY && mem_ready) begin
                if_data <= mem_rdata;
            end
            // mem_we still holds the direction of the access completing now.
            if (state == DM_BUSY && mem_ready) begin
                dm_rdata <= mem_we ? '0 : mem_rdata;
            end

            if (arbEn) begin
                mem_req <= grantDm | grantIf;
                if (grantDm) begin
                    mem_we    <= dm_wr;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else if (grantIf) begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_we    <= 1'b0;
                end
            end

            if (conflictHit && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level
// model of who owns the memory each cycle.
module tb_mem_port_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int DM_MAX = 4;
    localparam int NONE   = 0;
    localparam int FETCH  = 1;
    localparam int DATA   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_data;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          stall_f;
    logic          stall_m;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [15:0]   conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DM_MAX(DM_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .conflict_cnt(conflict_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model: which port owns the memory, the access it presented, and expected outputs.
    int          owner;
    int          starv;
    logic        eIfValid, eDmValid, eMemReq, eMemWe;
    logic [15:0] eIfData, eDmRdata, eMemAddr, eMemWdata, eCnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelClear();
        owner = NONE; starv = 0;
        eIfValid = 0; eDmValid = 0; eMemReq = 0; eMemWe = 0;
        eIfData = 0; eDmRdata = 0; eMemAddr = 0; eMemWdata = 0; eCnt = 0;
    endtask

    task automatic modelStep();
        bit ifE, dmE, free, done;
        int win;
        if (!reset) begin
            modelClear();
            return;
        end
        ifE  = if_req && !eIfValid;
        dmE  = (dm_rd || dm_wr) && !eDmValid;
        free = (owner == NONE) || mem_ready;
        done = (owner != NONE) && mem_ready;
        win  = owner;
        if (free) begin
            if (dmE && !(ifE && starv == DM_MAX)) win = DATA;
            else if (ifE)                         win = FETCH;
            else                                  win = NONE;
        end
        if (ifE && (owner == DATA || (free && win == DATA)) && eCnt != 16'hFFFF) eCnt++;
        if (!ifE || (free && win == FETCH)) starv = 0;
        else if (free && win == DATA)       starv++;
        if (done && owner == FETCH) eIfData = mem_rdata;
        if (done && owner == DATA)  eDmRdata = eMemWe ? 16'h0 : mem_rdata;
        eIfValid = done && owner == FETCH;
        eDmValid = done && owner == DATA;
        if (free) begin
            owner   = win;
            eMemReq = (win != NONE);
            if (win == DATA) begin
                eMemWe = dm_wr; eMemAddr = dm_addr; eMemWdata = dm_wdata;
            end else if (win == FETCH) begin
                eMemWe = 0; eMemAddr = if_addr;
            end else begin
                eMemWe = 0;
            end
        end
    endtask

    task automatic checkAll();
        chk("if_valid", if_valid, eIfValid);
        chk("if_data", if_data, eIfData);
        chk("dm_valid", dm_valid, eDmValid);
        chk("dm_rdata", dm_rdata, eDmRdata);
        chk("mem_req", mem_req, eMemReq);
        chk("conflict_cnt", conflict_cnt, eCnt);
        chk("stall_f", stall_f, if_req && !eIfValid);
        chk("stall_m", stall_m, (dm_rd || dm_wr) && !eDmValid);
        chk("starv_cnt", dut.starvCnt, starv);
        if (eMemReq) begin
            chk("mem_addr", mem_addr, eMemAddr);
            chk("mem_we", mem_we, eMemWe);
            if (eMemWe) chk("mem_wdata", mem_wdata, eMemWdata);
        end
    endtask

    // Inputs are already applied; check, advance the model, cross one clock edge.
    task automatic cycle();
        #2;
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 0;
        cycle();
        cycle();
        reset = 1;
    endtask

    initial begin
        int dmGrants;
        bit fetchSeen;
        bit lastFree;
        modelClear();
        idleInputs();
        reset = 0;
        @(posedge clk);
        #1;
        modelStep();

        // Reset state
        cycle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cnt", conflict_cnt, 0);
        reset = 1;

        // Lone fetch
        if_req = 1; if_addr = 16'h0010; mem_ready = 1; mem_rdata = 16'h1234;
        cycle();
        chk("lone_req", mem_req, 1);
        chk("lone_addr", mem_addr, 16'h0010);
        cycle();
        chk("lone_valid", if_valid, 1);
        chk("lone_data", if_data, 16'h1234);
        cycle();
        if_req = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Simultaneous fetch and load; requesters drop the cycle after their pulse
        doReset();
        if_req = 1; if_addr = 16'h0020; dm_rd = 1; dm_addr = 16'h0100;
        mem_ready = 1; mem_rdata = 16'h5A5A;
        cycle();
        chk("simul_data_first", mem_addr, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            if (dm_valid) dm_rd = 0;
            if (if_valid) if_req = 0;
            mem_rdata = 16'h5A00 + 16'(i);
            cycle();
        end

        // Starvation guard: data held with fresh address, memory ready every other cycle
        doReset();
        if_req = 1; if_addr = 16'h0300; dm_wr = 1;
        dmGrants = 0; fetchSeen = 0;
        for (int i = 0; i < 8; i++) begin
            dm_addr = 16'h0400 + 16'(i); dm_wdata = 16'(i);
            mem_ready = (i % 2 == 1);
            lastFree = !mem_req || mem_ready;
            cycle();
            if (lastFree && mem_req && !fetchSeen) begin
                if (mem_we) dmGrants++;
                else begin
                    fetchSeen = 1;
                    chk("starv_clear", dut.starvCnt, 0);
                end
            end
        end
        chk("starv_dm_grants", dmGrants, DM_MAX);
        chk("starv_fetch_seen", fetchSeen, 1);

        // Wait states on a store with fetch pending
        doReset();
        if_req = 1; if_addr = 16'h0040;
        dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF; mem_rdata = 16'h7777;
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("ws_req", mem_req, 1);
            chk("ws_we", mem_we, 1);
            chk("ws_addr", mem_addr, 16'h0200);
            chk("ws_wdata", mem_wdata, 16'hBEEF);
            mem_ready = (i == 3);
            cycle();
        end
        chk("ws_dm_valid", dm_valid, 1);
        chk("ws_rdata_zero", dm_rdata, 0);
        chk("ws_no_bubble", mem_req, 1);
        dm_wr = 0;
        for (int i = 0; i < 6; i++) begin
            if (if_valid) if_req = 0;
            cycle();
        end

        // Reset mid-access
        doReset();
        if_req = 1; dm_rd = 1; dm_addr = 16'h0500;
        cycle();
        cycle();
        reset = 0;
        cycle();
        chk("midrst_req", mem_req, 0);
        chk("midrst_valid", dm_valid, 0);
        chk("midrst_cnt", conflict_cnt, 0);
        reset = 1;
        cycle();

        // Counter saturation
        doReset();
        if_req = 1; dm_rd = 1; dm_addr = 16'h0600;
        cycle();
        force dut.conflict_cnt = 16'hFFFE;
        #1;
        release dut.conflict_cnt;
        eCnt = 16'hFFFE;
        for (int i = 0; i < 4; i++) cycle();
        chk("sat_hold", conflict_cnt, 16'hFFFF);

        // Random traffic
        doReset();
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 99) != 0);
            if_req    = ($urandom_range(0, 99) < 60);
            dm_rd     = ($urandom_range(0, 99) < 45);
            dm_wr     = ($urandom_range(0, 99) < 30);
            if_addr   = 16'($urandom);
            dm_addr   = 16'($urandom);
            dm_wdata  = 16'($urandom);
            mem_rdata = 16'($urandom);
            mem_ready = ($urandom_range(0, 99) < 55);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
